strobe_gen: RTL and testbench

//   Programmable enable-strobe generator that sits directly upstream of the

---
 rtl/strobe_gen_if.sv | 26 ++
 rtl/strobe_gen.sv | 117 +++++++++++
 tb/tb_strobe_gen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/strobe_gen_if.sv
// Control/status bundle between a burst controller and strobe_gen.
// The controller uses the master modport; strobe_gen uses the slave modport.
interface strobe_gen_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
);
    logic                   start;
    logic                   stop;
    logic                   hold;
    logic [DATA_WIDTH-1:0]  period;
    logic [COUNT_WIDTH-1:0] num_pulses;
    logic                   strobe;
    logic                   busy;
    logic                   done;
    logic [COUNT_WIDTH-1:0] pulses_left;

    modport master (
        output start, stop, hold, period, num_pulses,
        input  strobe, busy, done, pulses_left
    );

    modport slave (
        input  start, stop, hold, period, num_pulses,
        output strobe, busy, done, pulses_left
    );
endinterface

// File: rtl/strobe_gen.sv
// Programmable enable-strobe generator: one-cycle strobe every P clocks,
// for N strobes or continuously (N=0), with start/busy/done handshake.
module strobe_gen #(
    parameter string ARCHITECTURE = "BEHAVIORAL",
    parameter int    DATA_WIDTH   = 8,
    parameter int    COUNT_WIDTH  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    strobe_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    generate
        if (ARCHITECTURE == "BEHAVIORAL") begin : g_behav
            state_t                 r_state, w_state_next;
            logic [DATA_WIDTH-1:0]  r_period, w_period_next;
            logic [DATA_WIDTH-1:0]  r_presc, w_presc_next;
            logic [DATA_WIDTH-1:0]  w_period_eff;
            logic [COUNT_WIDTH-1:0] r_left, w_left_next;
            logic                   r_cont, w_cont_next;
            logic                   r_strobe, w_strobe_next;
            logic                   r_busy, w_busy_next;
            logic                   r_done, w_done_next;

            // A zero period behaves as a strobe every clock.
            assign w_period_eff = (bus.period == '0) ? DATA_WIDTH'(1) : bus.period;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state  <= ST_IDLE;
                    r_period <= '0;
                    r_presc  <= '0;
                    r_left   <= '0;
                    r_cont   <= 1'b0;
                    r_strobe <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end else begin
                    r_state  <= w_state_next;
                    r_period <= w_period_next;
                    r_presc  <= w_presc_next;
                    r_left   <= w_left_next;
                    r_cont   <= w_cont_next;
                    r_strobe <= w_strobe_next;
                    r_busy   <= w_busy_next;
                    r_done   <= w_done_next;
                end
            end

            always_comb begin
                w_state_next  = r_state;
                w_period_next = r_period;
                w_presc_next  = r_presc;
                w_left_next   = r_left;
                w_cont_next   = r_cont;
                w_strobe_next = 1'b0;
                w_busy_next   = r_busy;
                w_done_next   = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        // stop has priority over start while idle
                        if (bus.start && !bus.stop) begin
                            w_state_next  = ST_RUN;
                            w_period_next = w_period_eff;
                            w_presc_next  = w_period_eff - DATA_WIDTH'(1);
                            w_left_next   = bus.num_pulses;
                            w_cont_next   = (bus.num_pulses == '0);
                            w_busy_next   = 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // Burst ends one edge after the strobe that emptied pulses_left.
                        if (bus.stop || (!r_cont && r_left == '0)) begin
                            w_state_next = ST_DONE;
                            w_busy_next  = 1'b0;
                            w_done_next  = 1'b1;
                        end else if (!bus.hold) begin
                            if (r_presc == '0) begin
                                w_strobe_next = 1'b1;
                                w_presc_next  = r_period - DATA_WIDTH'(1);
                                if (!r_cont) begin
                                    w_left_next = r_left - COUNT_WIDTH'(1);
                                end
                            end else begin
                                w_presc_next = r_presc - DATA_WIDTH'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        w_state_next = ST_IDLE;
                    end
                    default: begin
                        w_state_next = ST_IDLE;
                        w_busy_next  = 1'b0;
                    end
                endcase
            end

            assign bus.strobe      = r_strobe;
            assign bus.busy        = r_busy;
            assign bus.done        = r_done;
            assign bus.pulses_left = r_left;
        end else begin : g_none
            assign bus.strobe      = 1'b0;
            assign bus.busy        = 1'b0;
            assign bus.done        = 1'b0;
            assign bus.pulses_left = '0;
        end
    endgenerate

endmodule

// File: tb/tb_strobe_gen.sv
// Self-checking bench for strobe_gen: per-edge expected outputs derived from
// the strobe/done timing rules are queued and compared after each clock edge.
module tb_strobe_gen;

    logic clk;
    logic rst_n;

    strobe_gen_if #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) sg_if ();

    strobe_gen #(
        .ARCHITECTURE ("BEHAVIORAL"),
        .DATA_WIDTH   (8),
        .COUNT_WIDTH  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sg_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic strobe;
        logic busy;
        logic done;
        int   pl;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t x);
        check({tag, " strobe"}, int'(sg_if.strobe), int'(x.strobe));
        check({tag, " busy"},   int'(sg_if.busy),   int'(x.busy));
        check({tag, " done"},   int'(sg_if.done),   int'(x.done));
        check({tag, " left"},   int'(sg_if.pulses_left), x.pl);
        check({tag, " excl"},   int'(sg_if.strobe & sg_if.done), 0);
    endtask

    // Drives one burst launched at edge 0. The expectation counts un-held
    // clocks since launch: a strobe lands on every P-th one, done follows
    // one edge after the N-th strobe or on the stop edge.
    task automatic run_burst(input string name, input int p, input int n,
                             input int stop_e, input int hold_lo, input int hold_hi,
                             input int start_last, input int abort_e);
        int   peff;
        int   unheld;
        int   cnt;
        int   done_e;
        int   pl;
        logic held;
        exp_t x;
        exp_t g;
        peff   = (p == 0) ? 1 : p;
        unheld = 0;
        cnt    = 0;
        done_e = -1;
        pl     = n;
        for (int e = 0; e < 400; e++) begin
            held = (e >= hold_lo) && (e <= hold_hi);
            sg_if.start      = (e <= start_last);
            sg_if.stop       = (e == stop_e);
            sg_if.hold       = held;
            sg_if.period     = (e == 0) ? 8'(p) : 8'(p + 7);
            sg_if.num_pulses = (e == 0) ? 16'(n) : 16'(n + 3);
            x = '{strobe: 1'b0, busy: 1'b0, done: 1'b0, pl: pl};
            if (e == 0) begin
                x.busy = 1'b1;
            end else if (done_e >= 0) begin
                x.busy = 1'b0;
            end else if (e == stop_e || (n > 0 && cnt == n)) begin
                x.done = 1'b1;
                done_e = e;
            end else if (held) begin
                x.busy = 1'b1;
            end else begin
                x.busy = 1'b1;
                unheld++;
                if (unheld % peff == 0) begin
                    x.strobe = 1'b1;
                    cnt++;
                    if (n > 0) pl = n - cnt;
                end
            end
            x.pl = pl;
            q.push_back(x);
            @(posedge clk);
            #1;
            g = q.pop_front();
            check_outputs($sformatf("%s e%0d", name, e), g);
            $display("%s edge %0d: strobe=%0b busy=%0b done=%0b left=%0d",
                     name, e, sg_if.strobe, sg_if.busy, sg_if.done, sg_if.pulses_left);
            if (e == abort_e) return;
            if (done_e >= 0 && e == done_e + 1) return;
        end
        check({name, " timeout"}, 1, 0);
    endtask

    task automatic idle_inputs();
        sg_if.start      = 1'b0;
        sg_if.stop       = 1'b0;
        sg_if.hold       = 1'b0;
        sg_if.period     = '0;
        sg_if.num_pulses = '0;
    endtask

    initial begin
        exp_t z;
        z = '{strobe: 1'b0, busy: 1'b0, done: 1'b0, pl: 0};
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", z);
        @(negedge clk);
        rst_n = 1'b1;

        run_burst("t1_p4n3",   4, 3, -1, 1, 0, 0, -1);
        run_burst("t2_p0n5",   0, 5, -1, 1, 0, 0, -1);
        run_burst("t3_cont",   3, 0, 10, 1, 0, 0, -1);
        run_burst("t4_hold",   2, 4, -1, 3, 6, 0, -1);

        // start held through busy and DONE is ignored; next edge (IDLE) accepts it
        run_burst("t5_busy",   1, 1, -1, 1, 0, 3, -1);
        run_burst("t5_again",  4, 3, -1, 1, 0, 0, -1);

        sg_if.start = 1'b1;
        sg_if.stop  = 1'b1;
        sg_if.period = 8'd2;
        sg_if.num_pulses = 16'd2;
        @(posedge clk);
        #1;
        check_outputs("t5_startstop", z);
        $display("t5_startstop: busy=%0b", sg_if.busy);
        idle_inputs();
        @(posedge clk);
        #1;
        check_outputs("t5_after", z);

        run_burst("t6_pre",    5, 10, -1, 1, 0, 0, 17);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("t6_async", z);
        $display("t6 async reset: strobe=%0b busy=%0b done=%0b left=%0d",
                 sg_if.strobe, sg_if.busy, sg_if.done, sg_if.pulses_left);
        idle_inputs();
        @(posedge clk);
        #1;
        check_outputs("t6_held", z);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("t6_nodone", z);
        run_burst("t6_post",   4, 3, -1, 1, 0, 0, -1);

        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
